if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 118 +++++++++++
 tb/tb_if_stage.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register and a BOOT/RUN/HALTED
// control FSM, with stall, redirect-flush, halt and a saturating delivered-instruction count.
module if_stage #(
    parameter int unsigned             PC_W      = 8,
    parameter int unsigned             INSTR_W   = 32,
    parameter logic [PC_W-1:0]         RESET_PC  = '0,
    parameter logic [INSTR_W-1:0]      NOP_INSTR = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                redirect_valid,
    input  logic [PC_W-1:0]     redirect_target,
    input  logic                halt_req,
    output logic [PC_W-1:0]     imem_addr,
    input  logic [INSTR_W-1:0]  imem_data,
    output logic [INSTR_W-1:0]  ifid_instr,
    output logic [PC_W-1:0]     ifid_pc,
    output logic                ifid_valid,
    output logic                halted,
    output logic [15:0]         fetch_count
);

    typedef enum logic [1:0] {
        S_BOOT   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [PC_W-1:0]      pc_q, pc_d;
    logic [INSTR_W-1:0]   instr_q, instr_d;
    logic [PC_W-1:0]      ifid_pc_q, ifid_pc_d;
    logic                 valid_q, valid_d;
    logic                 halted_q, halted_d;
    logic [15:0]          count_q, count_d;

    assign imem_addr   = pc_q;
    assign ifid_instr  = instr_q;
    assign ifid_pc     = ifid_pc_q;
    assign ifid_valid  = valid_q;
    assign halted      = halted_q;
    assign fetch_count = count_q;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        ifid_pc_d = ifid_pc_q;
        valid_d   = valid_q;
        count_d   = count_q;

        unique case (state_q)
            S_BOOT: begin
                state_d   = S_RUN;
                instr_d   = NOP_INSTR;
                ifid_pc_d = '0;
                valid_d   = 1'b0;
            end
            S_RUN: begin
                // Halt wins over stall for IF/ID, but a same-cycle redirect still steers the PC.
                if (halt_req) begin
                    state_d   = S_HALTED;
                    instr_d   = NOP_INSTR;
                    ifid_pc_d = '0;
                    valid_d   = 1'b0;
                    if (redirect_valid) begin
                        pc_d = redirect_target;
                    end
                end else if (redirect_valid) begin
                    pc_d      = redirect_target;
                    instr_d   = NOP_INSTR;
                    ifid_pc_d = '0;
                    valid_d   = 1'b0;
                end else if (!stall) begin
                    pc_d      = pc_q + 1'b1;
                    instr_d   = imem_data;
                    ifid_pc_d = pc_q;
                    valid_d   = 1'b1;
                    if (count_q != '1) begin
                        count_d = count_q + 16'd1;
                    end
                end
            end
            S_HALTED: begin
                instr_d   = NOP_INSTR;
                ifid_pc_d = '0;
                valid_d   = 1'b0;
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase

        halted_d = (state_d == S_HALTED);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_BOOT;
            pc_q      <= RESET_PC;
            instr_q   <= NOP_INSTR;
            ifid_pc_q <= '0;
            valid_q   <= 1'b0;
            halted_q  <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            ifid_pc_q <= ifid_pc_d;
            valid_q   <= valid_d;
            halted_q  <= halted_d;
            count_q   <= count_d;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: a vector table plus hand-written reset, halt and saturation
// sequences; expected outputs queue up as stimulus is driven and are popped after each edge.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [7:0]  redirect_target;
    logic        halt_req;
    logic [7:0]  imem_addr;
    logic [31:0] imem_data;
    logic [31:0] ifid_instr;
    logic [7:0]  ifid_pc;
    logic        ifid_valid;
    logic        halted;
    logic [15:0] fetch_count;

    int unsigned errors = 0;
    int unsigned checks = 0;

    if_stage #(
        .PC_W      (8),
        .INSTR_W   (32),
        .RESET_PC  (8'h00),
        .NOP_INSTR (32'h0000_0000)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .halt_req        (halt_req),
        .imem_addr       (imem_addr),
        .imem_data       (imem_data),
        .ifid_instr      (ifid_instr),
        .ifid_pc         (ifid_pc),
        .ifid_valid      (ifid_valid),
        .halted          (halted),
        .fetch_count     (fetch_count)
    );

    always #5 clk = ~clk;

    assign imem_data = 32'h1000_0000 + {24'h0, imem_addr};

    typedef struct {
        logic        s;
        logic        rv;
        logic [7:0]  tgt;
        logic        h;
        logic [7:0]  e_addr;
        logic [7:0]  e_pc;
        logic        e_valid;
        logic        e_halted;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one vector, queue its expectation, and compare right after the next rising edge.
    task automatic step(input vec_t v);
        vec_t        e;
        logic [31:0] e_instr;
        stall           = v.s;
        redirect_valid  = v.rv;
        redirect_target = v.tgt;
        halt_req        = v.h;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e       = exp_q.pop_front();
        e_instr = e.e_valid ? (32'h1000_0000 + {24'h0, e.e_pc}) : 32'h0;
        check("imem_addr",   {24'h0, imem_addr},   {24'h0, e.e_addr});
        check("ifid_pc",     {24'h0, ifid_pc},     {24'h0, e.e_pc});
        check("ifid_valid",  {31'h0, ifid_valid},  {31'h0, e.e_valid});
        check("ifid_instr",  ifid_instr,           e_instr);
        check("halted",      {31'h0, halted},      {31'h0, e.e_halted});
        check("fetch_count", {16'h0, fetch_count}, {16'h0, e.e_cnt});
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_addr"},   {24'h0, imem_addr},   32'h0);
        check({tag, "_valid"},  {31'h0, ifid_valid},  32'h0);
        check({tag, "_ifidpc"}, {24'h0, ifid_pc},     32'h0);
        check({tag, "_instr"},  ifid_instr,           32'h0);
        check({tag, "_halted"}, {31'h0, halted},      32'h0);
        check({tag, "_count"},  {16'h0, fetch_count}, 32'h0);
    endtask

    // Synchronous-style reset: hold rst over two edges, release mid-cycle.
    task automatic do_reset();
        stall = 0; redirect_valid = 0; redirect_target = 0; halt_req = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("rst");
        rst = 1'b0;
    endtask

    vec_t tbl[$];

    initial begin
        // {stall, rv, tgt, halt, addr, ifid_pc, valid, halted, count}
        tbl = '{
            '{0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 16'd0},   // BOOT cycle
            '{0, 0, 8'h00, 0, 8'h01, 8'h00, 1, 0, 16'd1},
            '{0, 0, 8'h00, 0, 8'h02, 8'h01, 1, 0, 16'd2},
            '{0, 0, 8'h00, 0, 8'h03, 8'h02, 1, 0, 16'd3},
            '{0, 0, 8'h00, 0, 8'h04, 8'h03, 1, 0, 16'd4},
            '{0, 0, 8'h00, 0, 8'h05, 8'h04, 1, 0, 16'd5},
            '{1, 0, 8'h00, 0, 8'h05, 8'h04, 1, 0, 16'd5},   // stall x3 at pc=5
            '{1, 0, 8'h00, 0, 8'h05, 8'h04, 1, 0, 16'd5},
            '{1, 0, 8'h00, 0, 8'h05, 8'h04, 1, 0, 16'd5},
            '{0, 0, 8'h00, 0, 8'h06, 8'h05, 1, 0, 16'd6},
            '{1, 1, 8'h40, 0, 8'h40, 8'h00, 0, 0, 16'd6},   // redirect beats stall
            '{0, 0, 8'h00, 0, 8'h41, 8'h40, 1, 0, 16'd7},
            '{0, 1, 8'hFE, 0, 8'hFE, 8'h00, 0, 0, 16'd7},
            '{0, 0, 8'h00, 0, 8'hFF, 8'hFE, 1, 0, 16'd8},
            '{0, 0, 8'h00, 0, 8'h00, 8'hFF, 1, 0, 16'd9},   // pc wraps
            '{0, 0, 8'h00, 0, 8'h01, 8'h00, 1, 0, 16'd10},
            '{0, 1, 8'h09, 0, 8'h09, 8'h00, 0, 0, 16'd10},
            '{0, 0, 8'h00, 1, 8'h09, 8'h00, 0, 1, 16'd10},  // halt at pc=9
            '{1, 1, 8'h33, 1, 8'h09, 8'h00, 0, 1, 16'd10},  // ignored while halted
            '{0, 0, 8'h00, 0, 8'h09, 8'h00, 0, 1, 16'd10}
        };

        rst = 1'b1;
        stall = 0; redirect_valid = 0; redirect_target = 0; halt_req = 0;
        #1;
        check_reset_state("por");
        do_reset();
        foreach (tbl[i]) step(tbl[i]);

        // Async reset out of HALTED, no clock edge needed.
        #2 rst = 1'b1;
        #1;
        check_reset_state("async_halted");
        @(posedge clk);
        #1 rst = 1'b0;
        step('{0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 16'd0});
        step('{0, 0, 8'h00, 0, 8'h01, 8'h00, 1, 0, 16'd1});
        step('{0, 0, 8'h00, 0, 8'h02, 8'h01, 1, 0, 16'd2});
        // Halt with simultaneous redirect: PC takes the target then freezes.
        step('{0, 1, 8'h20, 1, 8'h20, 8'h00, 0, 1, 16'd2});
        step('{0, 1, 8'h50, 0, 8'h20, 8'h00, 0, 1, 16'd2});

        // Reset while stalled.
        do_reset();
        step('{0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 16'd0});
        step('{0, 0, 8'h00, 0, 8'h01, 8'h00, 1, 0, 16'd1});
        step('{1, 0, 8'h00, 0, 8'h01, 8'h00, 1, 0, 16'd1});
        stall = 1'b1; redirect_valid = 1'b1; redirect_target = 8'h77;
        #2 rst = 1'b1;
        #1;
        check_reset_state("async_stall");
        @(posedge clk);
        #1 rst = 1'b0;
        stall = 0; redirect_valid = 0;

        // Saturation: BOOT, then 65534 deliveries reach 0xFFFE.
        step('{0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 16'd0});
        stall = 0; redirect_valid = 0; halt_req = 0;
        repeat (65534) @(posedge clk);
        #1;
        check("sat_pre_count", {16'h0, fetch_count}, 32'h0000_FFFE);
        step('{0, 0, 8'h00, 0, 8'hFF, 8'hFE, 1, 0, 16'hFFFF});
        step('{0, 0, 8'h00, 0, 8'h00, 8'hFF, 1, 0, 16'hFFFF});
        step('{0, 0, 8'h00, 0, 8'h01, 8'h00, 1, 0, 16'hFFFF});

        check("sb_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
